// File: rtl/sfx_scheduler_pkg.sv
// apu_sched_pkg: shared state encoding and requester indices for the sound-effect scheduler
package apu_sched_pkg;
    typedef enum logic [1:0] {IDLE, START, PLAY, COOLDOWN} sched_state_t;
    localparam int NUM_REQ = 3;
    localparam logic [1:0] SFX_SHEEP = 2'd0;
    localparam logic [1:0] SFX_SWORD = 2'd1;
    localparam logic [1:0] SFX_PLAYER = 2'd2;
    function automatic logic [NUM_REQ-1:0] id_mask(input logic [1:0] id);
        return NUM_REQ'(1) << id;
    endfunction
endpackage

// File: rtl/sfx_scheduler_pri_enc.sv
// sfx_pri_enc: highest-index-wins encoder over the three requesters
module sfx_pri_enc
    import apu_sched_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    output logic               valid,
    output logic [1:0]         idx
);
    assign valid = |req;
    assign idx = req[SFX_PLAYER] ? SFX_PLAYER : req[SFX_SWORD] ? SFX_SWORD : SFX_SHEEP;
endmodule

// File: rtl/sfx_scheduler.sv
// sfx_scheduler: queues collision requests and grants the single effect voice by fixed priority
module sfx_scheduler
    import apu_sched_pkg::*;
#(
    parameter int SFX_FRAMES      = 30,
    parameter int COOLDOWN_FRAMES = 4,
    parameter int STEP_W          = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_tick,
    input  logic [2:0]        req,
    output logic              sfx_start,
    output logic              sfx_active,
    output logic [1:0]        sfx_id,
    output logic [STEP_W-1:0] sfx_step,
    output logic [2:0]        pending,
    output logic              busy
);
    localparam int CD_W = COOLDOWN_FRAMES > 1 ? $clog2(COOLDOWN_FRAMES) : 1;
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(SFX_FRAMES - 1);
    localparam logic [CD_W-1:0] CD_LAST = CD_W'(COOLDOWN_FRAMES > 0 ? COOLDOWN_FRAMES - 1 : 0);
    localparam sched_state_t AFTER_PLAY = COOLDOWN_FRAMES == 0 ? IDLE : COOLDOWN;

    sched_state_t state;
    logic [2:0] req_q, rise, clr;
    logic [CD_W-1:0] cd_cnt;
    logic p_valid, grant;
    logic [1:0] p_idx;

    sfx_pri_enc u_pri (.req(pending), .valid(p_valid), .idx(p_idx));

    // preemption only by a strictly higher index; equal or lower waits
    assign grant = p_valid && (state == IDLE || (state == PLAY && p_idx > sfx_id));
    assign rise = req & ~req_q;
    assign clr = grant ? id_mask(p_idx) : 3'b000;
    assign sfx_start = state == START;
    assign sfx_active = state == START || state == PLAY;
    assign busy = state != IDLE;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            req_q <= '0;
            pending <= '0;
            sfx_id <= '0;
            sfx_step <= '0;
            cd_cnt <= '0;
        end else begin
            req_q <= req;
            pending <= (pending & ~clr) | rise;
            if (grant) begin
                state <= START;
                sfx_id <= p_idx;
                sfx_step <= '0;
            end else begin
                case (state)
                    START: state <= PLAY;
                    PLAY: if (frame_tick) begin
                        if (sfx_step == STEP_LAST) begin
                            sfx_step <= '0;
                            cd_cnt <= '0;
                            state <= AFTER_PLAY;
                        end else begin
                            sfx_step <= sfx_step + STEP_W'(1);
                        end
                    end
                    COOLDOWN: if (frame_tick) begin
                        cd_cnt <= cd_cnt == CD_LAST ? '0 : cd_cnt + CD_W'(1);
                        if (cd_cnt == CD_LAST) state <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule
